// File: rtl/pc_sequencer.sv
// Instruction-cycle sequencer: walks fetch/decode/exec/mem/writeback and issues one PC command per retired instruction.
// Optional single-step gate via CTRL_SINGLE_STEP_EN (adds I_step and S_STEP); default build leaves state 7 unused.
module pc_sequencer #(
   parameter int unsigned FETCH_TIMEOUT = 8
) (
   input  logic       I_clk,
   input  logic       I_rst,
   input  logic       I_en,
   input  logic       I_mem_ready,
   input  logic [3:0] I_instr_op,
   input  logic       I_flag_zero,
`ifdef CTRL_SINGLE_STEP_EN
   input  logic       I_step,
`endif
   output logic [1:0] O_pc_op,
   output logic       O_fetch_req,
   output logic       O_decode_en,
   output logic       O_alu_en,
   output logic       O_mem_en,
   output logic       O_reg_we,
   output logic [2:0] O_state,
   output logic       O_halted,
   output logic       O_fault
);

   // state    | meaning
   // S_RESET  | PC clear, wait for enable
   // S_FETCH  | instruction fetch, wait for I_mem_ready
   // S_DECODE | latch instruction class
   // S_EXEC   | ALU operation, branch/jump resolution
   // S_MEM    | load/store data access, wait for I_mem_ready
   // S_WB     | register write-back, PC increment
   // S_HALT   | stopped (halt op or timeout) until reset
   // S_STEP   | single-step gate before fetch
   localparam logic [2:0] S_RESET  = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_HALT   = 3'd6;
   localparam logic [2:0] S_STEP   = 3'd7;

   localparam logic [1:0] PC_HOLD  = 2'b00;
   localparam logic [1:0] PC_INC   = 2'b01;
   localparam logic [1:0] PC_LOAD  = 2'b10;
   localparam logic [1:0] PC_CLEAR = 2'b11;

   localparam logic [3:0] OP_LOAD  = 4'hA;
   localparam logic [3:0] OP_STORE = 4'hB;
   localparam logic [3:0] OP_BRZ   = 4'hC;
   localparam logic [3:0] OP_JUMP  = 4'hD;
   localparam logic [3:0] OP_SKIP  = 4'hE;
   localparam logic [3:0] OP_HALT  = 4'hF;

   // Last waiting cycle index; a miss here is the FETCH_TIMEOUT-th miss.
   localparam logic [3:0] WAIT_LAST = 4'(FETCH_TIMEOUT - 1);

`ifdef CTRL_SINGLE_STEP_EN
   localparam logic [2:0] S_NEXT_FETCH = S_STEP;
`else
   localparam logic [2:0] S_NEXT_FETCH = S_FETCH;
`endif

   logic [2:0] state_q, state_d;
   logic [3:0] wait_q, wait_d;
   logic [3:0] class_q, class_d;
   logic       fault_q, fault_d;

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      class_d = class_q;
      fault_d = fault_q;
      if (I_en) begin
         case (state_q)
            S_RESET: begin
               state_d = S_NEXT_FETCH;
               wait_d  = 4'd0;
            end
            S_FETCH, S_MEM: begin
               if (I_mem_ready) begin
                  wait_d = 4'd0;
                  if (state_q == S_FETCH)       state_d = S_DECODE;
                  else if (class_q == OP_LOAD)  state_d = S_WB;
                  else                          state_d = S_NEXT_FETCH;
               end else if (wait_q == WAIT_LAST) begin
                  state_d = S_HALT;
                  fault_d = 1'b1;
               end else begin
                  wait_d = wait_q + 4'd1;
               end
            end
            S_DECODE: begin
               class_d = I_instr_op;
               state_d = (I_instr_op == OP_HALT) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
               wait_d = 4'd0;
               if (class_q <= 4'h9)                              state_d = S_WB;
               else if (class_q == OP_LOAD || class_q == OP_STORE) state_d = S_MEM;
               else                                              state_d = S_NEXT_FETCH;
            end
            S_WB: begin
               state_d = S_NEXT_FETCH;
               wait_d  = 4'd0;
            end
            S_HALT: state_d = S_HALT;
`ifdef CTRL_SINGLE_STEP_EN
            S_STEP: begin
               if (I_step) begin
                  state_d = S_FETCH;
                  wait_d  = 4'd0;
               end
            end
`endif
            default: state_d = S_RESET;
         endcase
      end
   end

   // PC command: state-decoded, qualified by the branch flag and the store-completion handshake.
   always_comb begin
      O_pc_op = PC_HOLD;
      if (I_en) begin
         case (state_q)
            S_RESET: O_pc_op = PC_CLEAR;
            S_EXEC: begin
               if (class_q == OP_JUMP)      O_pc_op = PC_LOAD;
               else if (class_q == OP_BRZ)  O_pc_op = I_flag_zero ? PC_LOAD : PC_INC;
               else if (class_q == OP_SKIP) O_pc_op = PC_INC;
            end
            S_MEM:   if (class_q == OP_STORE && I_mem_ready) O_pc_op = PC_INC;
            S_WB:    O_pc_op = PC_INC;
            default: O_pc_op = PC_HOLD;
         endcase
      end
   end

   assign O_fetch_req = (state_q == S_FETCH);
   assign O_decode_en = (state_q == S_DECODE);
   assign O_alu_en    = (state_q == S_EXEC);
   assign O_mem_en    = (state_q == S_MEM);
   assign O_reg_we    = (state_q == S_WB);
   assign O_halted    = (state_q == S_HALT);
   assign O_fault     = fault_q;
   assign O_state     = state_q;

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state_q <= S_RESET;
         wait_q  <= 4'd0;
         class_q <= 4'd0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         class_q <= class_d;
         fault_q <= fault_d;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (default build, FETCH_TIMEOUT=8): vector table plus timeout/freeze/reset sequences.
module tb_pc_sequencer;

   logic       clk = 1'b0;
   logic       rst, en, rdy, fz;
   logic [3:0] op;
   logic [1:0] pc_op;
   logic       fetch_req, decode_en, alu_en, mem_en, reg_we, halted, fault;
   logic [2:0] state;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pc_sequencer #(.FETCH_TIMEOUT(8)) dut (
      .I_clk(clk), .I_rst(rst), .I_en(en), .I_mem_ready(rdy),
      .I_instr_op(op), .I_flag_zero(fz),
      .O_pc_op(pc_op), .O_fetch_req(fetch_req), .O_decode_en(decode_en),
      .O_alu_en(alu_en), .O_mem_en(mem_en), .O_reg_we(reg_we),
      .O_state(state), .O_halted(halted), .O_fault(fault)
   );

   // flags order: fetch, decode, alu, mem, reg_we, halted, fault
   localparam logic [6:0] FN = 7'b0000000;
   localparam logic [6:0] FF = 7'b1000000;
   localparam logic [6:0] FD = 7'b0100000;
   localparam logic [6:0] FA = 7'b0010000;
   localparam logic [6:0] FM = 7'b0001000;
   localparam logic [6:0] FW = 7'b0000100;
   localparam logic [6:0] FH = 7'b0000010;
   localparam logic [6:0] FX = 7'b0000011;

   typedef struct {
      logic       rst, en, rdy;
      logic [3:0] op;
      logic       fz;
      logic       chk;
      logic [11:0] exp;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(input logic r, input logic e, input logic m, input logic [3:0] o,
                              input logic z, input logic c, input logic [2:0] st,
                              input logic [1:0] pc, input logic [6:0] fl);
      vec_t t;
      t.rst = r; t.en = e; t.rdy = m; t.op = o; t.fz = z; t.chk = c;
      t.exp = {st, pc, fl};
      return t;
   endfunction

   task automatic step(input logic r, input logic e, input logic m, input logic [3:0] o,
                       input logic z, input logic c, input logic [11:0] exp, input string name);
      logic [11:0] got;
      @(negedge clk);
      rst = r; en = e; rdy = m; op = o; fz = z;
      #1;
      got = {state, pc_op, fetch_req, decode_en, alu_en, mem_en, reg_we, halted, fault};
      if (c) begin
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL %s: got st=%0d pc=%b fl=%b, want st=%0d pc=%b fl=%b",
                     name, got[11:9], got[8:7], got[6:0], exp[11:9], exp[8:7], exp[6:0]);
         end
      end
   endtask

   // Reset edge, then the S_RESET cycle; the DUT is in S_FETCH afterwards.
   task automatic reset_to_fetch(input string name);
      step(1, 1, 0, 4'h0, 0, 0, 12'h0, name);
      step(0, 1, 0, 4'h0, 0, 1, {3'd0, 2'b11, FN}, {name, "_rst"});
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; rdy = 1'b0; op = 4'h0; fz = 1'b0;

      // rst en rdy op fz chk | state pc flags
      tbl.push_back(v(1,1,0,4'h0,0,0, 3'd0,2'b00,FN));
      tbl.push_back(v(0,1,1,4'h3,0,1, 3'd0,2'b11,FN));   // ALU op path
      tbl.push_back(v(0,1,1,4'h3,0,1, 3'd1,2'b00,FF));
      tbl.push_back(v(0,1,1,4'h3,0,1, 3'd2,2'b00,FD));
      tbl.push_back(v(0,1,1,4'hD,0,1, 3'd3,2'b00,FA));   // op input ignored after decode
      tbl.push_back(v(0,1,1,4'h0,0,1, 3'd5,2'b01,FW));
      tbl.push_back(v(0,1,1,4'h0,0,1, 3'd1,2'b00,FF));
      tbl.push_back(v(0,1,1,4'hC,0,1, 3'd2,2'b00,FD));   // branch taken
      tbl.push_back(v(0,1,1,4'h0,1,1, 3'd3,2'b10,FA));
      tbl.push_back(v(0,1,1,4'h0,0,1, 3'd1,2'b00,FF));
      tbl.push_back(v(0,1,1,4'hC,0,1, 3'd2,2'b00,FD));   // branch not taken
      tbl.push_back(v(0,1,1,4'h0,0,1, 3'd3,2'b01,FA));
      tbl.push_back(v(0,1,1,4'h0,0,1, 3'd1,2'b00,FF));
      tbl.push_back(v(0,1,1,4'hD,0,1, 3'd2,2'b00,FD));   // jump
      tbl.push_back(v(0,1,1,4'h0,0,1, 3'd3,2'b10,FA));
      tbl.push_back(v(0,1,1,4'h0,0,1, 3'd1,2'b00,FF));
      tbl.push_back(v(0,1,1,4'hE,0,1, 3'd2,2'b00,FD));   // 0xE ignores zero flag
      tbl.push_back(v(0,1,1,4'h0,1,1, 3'd3,2'b01,FA));
      tbl.push_back(v(0,1,1,4'h0,0,1, 3'd1,2'b00,FF));
      tbl.push_back(v(0,1,1,4'hA,0,1, 3'd2,2'b00,FD));   // load, ready late
      tbl.push_back(v(0,1,1,4'h0,0,1, 3'd3,2'b00,FA));
      tbl.push_back(v(0,1,0,4'h0,0,1, 3'd4,2'b00,FM));
      tbl.push_back(v(0,1,0,4'h0,0,1, 3'd4,2'b00,FM));
      tbl.push_back(v(0,1,0,4'h0,0,1, 3'd4,2'b00,FM));
      tbl.push_back(v(0,1,1,4'h0,0,1, 3'd4,2'b00,FM));
      tbl.push_back(v(0,1,1,4'h0,0,1, 3'd5,2'b01,FW));
      tbl.push_back(v(0,1,1,4'h0,0,1, 3'd1,2'b00,FF));
      tbl.push_back(v(0,1,1,4'hB,0,1, 3'd2,2'b00,FD));   // store
      tbl.push_back(v(0,1,1,4'h0,0,1, 3'd3,2'b00,FA));
      tbl.push_back(v(0,1,0,4'h0,0,1, 3'd4,2'b00,FM));
      tbl.push_back(v(0,1,1,4'h0,0,1, 3'd4,2'b01,FM));
      tbl.push_back(v(0,1,1,4'h0,0,1, 3'd1,2'b00,FF));
      tbl.push_back(v(0,1,1,4'h3,0,1, 3'd2,2'b00,FD));   // disable while in WB
      tbl.push_back(v(0,1,1,4'h0,0,1, 3'd3,2'b00,FA));
      tbl.push_back(v(0,0,1,4'h0,0,1, 3'd5,2'b00,FW));
      tbl.push_back(v(0,0,1,4'h0,0,1, 3'd5,2'b00,FW));
      tbl.push_back(v(0,1,1,4'h0,0,1, 3'd5,2'b01,FW));
      tbl.push_back(v(0,1,1,4'h0,0,1, 3'd1,2'b00,FF));
      tbl.push_back(v(0,1,1,4'hF,0,1, 3'd2,2'b00,FD));   // halt op
      tbl.push_back(v(0,1,1,4'h0,0,1, 3'd6,2'b00,FH));
      tbl.push_back(v(0,1,1,4'h0,1,1, 3'd6,2'b00,FH));
      tbl.push_back(v(1,1,1,4'h0,0,1, 3'd6,2'b00,FH));
      tbl.push_back(v(0,1,0,4'h0,0,1, 3'd0,2'b11,FN));
      tbl.push_back(v(0,1,0,4'h0,0,1, 3'd1,2'b00,FF));

      for (int i = 0; i < tbl.size(); i++)
         step(tbl[i].rst, tbl[i].en, tbl[i].rdy, tbl[i].op, tbl[i].fz, tbl[i].chk,
              tbl[i].exp, $sformatf("row%0d", i));

      // Fetch timeout: eight misses, then halt with fault; reset clears both flags.
      reset_to_fetch("to");
      for (int i = 0; i < 8; i++)
         step(0, 1, 0, 4'h0, 0, 1, {3'd1, 2'b00, FF}, $sformatf("to_wait%0d", i));
      step(0, 1, 0, 4'h0, 0, 1, {3'd6, 2'b00, FX}, "to_halt");
      step(0, 1, 1, 4'h0, 0, 1, {3'd6, 2'b00, FX}, "to_stay");
      step(1, 1, 0, 4'h0, 0, 1, {3'd6, 2'b00, FX}, "to_rst_edge");
      step(0, 1, 0, 4'h0, 0, 1, {3'd0, 2'b11, FN}, "to_cleared");

      // Ready on the eighth waiting cycle is a success.
      reset_to_fetch("edge");
      for (int i = 0; i < 7; i++)
         step(0, 1, 0, 4'h0, 0, 1, {3'd1, 2'b00, FF}, $sformatf("edge_wait%0d", i));
      step(0, 1, 1, 4'h3, 0, 1, {3'd1, 2'b00, FF}, "edge_ready");
      step(0, 1, 1, 4'h3, 0, 1, {3'd2, 2'b00, FD}, "edge_decode");
      step(0, 1, 1, 4'h3, 0, 1, {3'd3, 2'b00, FA}, "edge_exec");

      // Disabled cycles do not advance the wait counter.
      reset_to_fetch("frz");
      for (int i = 0; i < 4; i++)
         step(0, 1, 0, 4'h0, 0, 1, {3'd1, 2'b00, FF}, $sformatf("frz_a%0d", i));
      for (int i = 0; i < 6; i++)
         step(0, 0, 0, 4'h0, 0, 1, {3'd1, 2'b00, FF}, $sformatf("frz_off%0d", i));
      for (int i = 0; i < 4; i++)
         step(0, 1, 0, 4'h0, 0, 1, {3'd1, 2'b00, FF}, $sformatf("frz_b%0d", i));
      step(0, 1, 0, 4'h0, 0, 1, {3'd6, 2'b00, FX}, "frz_halt");

      // Reset in the middle of a load wait.
      reset_to_fetch("mrst");
      step(0, 1, 1, 4'hA, 0, 1, {3'd1, 2'b00, FF}, "mrst_fetch");
      step(0, 1, 1, 4'hA, 0, 1, {3'd2, 2'b00, FD}, "mrst_decode");
      step(0, 1, 0, 4'h0, 0, 1, {3'd3, 2'b00, FA}, "mrst_exec");
      step(0, 1, 0, 4'h0, 0, 1, {3'd4, 2'b00, FM}, "mrst_mem0");
      step(1, 1, 0, 4'h0, 0, 1, {3'd4, 2'b00, FM}, "mrst_mem1");
      step(0, 1, 0, 4'h0, 0, 1, {3'd0, 2'b11, FN}, "mrst_reset");

      // Store whose data access never completes times out in S_MEM.
      reset_to_fetch("mto");
      step(0, 1, 1, 4'hB, 0, 1, {3'd1, 2'b00, FF}, "mto_fetch");
      step(0, 1, 1, 4'hB, 0, 1, {3'd2, 2'b00, FD}, "mto_decode");
      step(0, 1, 0, 4'h0, 0, 1, {3'd3, 2'b00, FA}, "mto_exec");
      for (int i = 0; i < 8; i++)
         step(0, 1, 0, 4'h0, 0, 1, {3'd4, 2'b00, FM}, $sformatf("mto_wait%0d", i));
      step(0, 1, 0, 4'h0, 0, 1, {3'd6, 2'b00, FX}, "mto_halt");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
